// File: rtl/serial_shiftsub_division.sv
// Unsigned restoring divider: one quotient bit per clock, dividend consumed MSB-first.
// Valid-in / valid-out handshake; a request is taken only while idle.
module serial_shiftsub_division #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dividend_valid,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             quotient_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dsr;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic             r_dbz;
    logic [CW-1:0]    r_count;

    // Only the trial value needs the extra bit; a stored remainder is always < divisor.
    logic [WIDTH:0]   w_trial;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_trial = {r_rem, r_dvd[WIDTH-1]};
    assign w_ge    = (w_trial >= {1'b0, r_dsr});
    assign w_diff  = w_trial[WIDTH-1:0] - r_dsr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (dividend_valid) begin
                    w_state_next = (divisor != '0) ? S_CALC : S_DONE;
                end
            end
            S_CALC: begin
                if (r_count == LAST_STEP) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        ready = (r_state == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd          <= '0;
            r_dsr          <= '0;
            r_quo          <= '0;
            r_rem          <= '0;
            r_dbz          <= 1'b0;
            r_count        <= '0;
            quotient_valid <= 1'b0;
            quotient       <= '0;
            remainder      <= '0;
            div_by_zero    <= 1'b0;
        end else begin
            quotient_valid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (dividend_valid) begin
                        if (divisor != '0) begin
                            r_dvd   <= dividend;
                            r_dsr   <= divisor;
                            r_quo   <= '0;
                            r_rem   <= '0;
                            r_dbz   <= 1'b0;
                            r_count <= '0;
                        end else begin
                            r_quo <= '1;
                            r_rem <= dividend;
                            r_dbz <= 1'b1;
                        end
                    end
                end
                S_CALC: begin
                    r_dvd   <= r_dvd << 1;
                    r_rem   <= w_ge ? w_diff : w_trial[WIDTH-1:0];
                    r_quo   <= (r_quo << 1) | WIDTH'(w_ge);
                    r_count <= r_count + 1'b1;
                end
                S_DONE: begin
                    quotient    <= r_quo;
                    remainder   <= r_rem;
                    div_by_zero <= r_dbz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_shiftsub_division.sv
// Self-checking bench for serial_shiftsub_division: table vectors with latency checks,
// hand-written corner sequences, and a full operand sweep through a result scoreboard.
module tb_serial_shiftsub_division;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         dividend_valid = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         ready;
    logic         quotient_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    serial_shiftsub_division #(.WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .dividend_valid (dividend_valid),
        .dividend       (dividend),
        .divisor        (divisor),
        .ready          (ready),
        .quotient_valid (quotient_valid),
        .quotient       (quotient),
        .remainder      (remainder),
        .div_by_zero    (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    res_t sb[$];
    res_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_acc = 0;
    int   n_pulse = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        res_t m;
        if (b == 0) begin
            m.q = {W{1'b1}};
            m.r = a;
            m.z = 1'b1;
        end else begin
            m.q = a / b;
            m.r = a % b;
            m.z = 1'b0;
        end
        return m;
    endfunction

    // Scoreboard: every pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && quotient_valid) begin
            n_pulse++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_pulse: got q=%0d r=%0d z=%0d expected no pulse",
                         quotient, remainder, div_by_zero);
            end else begin
                mon_e = sb.pop_front();
                $display("result q=%0d r=%0d z=%0d (exp q=%0d r=%0d z=%0d)",
                         quotient, remainder, div_by_zero, mon_e.q, mon_e.r, mon_e.z);
                check("quotient", 32'(quotient), 32'(mon_e.q));
                check("remainder", 32'(remainder), 32'(mon_e.r));
                check("div_by_zero", 32'(div_by_zero), 32'(mon_e.z));
            end
        end
    end

    // Waits for ready, presents one request for exactly the accept edge; returns at edge 0 + #1.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        k = 0;
        @(negedge clk);
        while (!ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready) begin
            n_vec++;
            n_err++;
            $display("FAIL ready_timeout: got ready=0 expected ready=1 within 50 cycles");
        end
        dividend       = a;
        divisor        = b;
        dividend_valid = 1'b1;
        sb.push_back(model(a, b));
        n_acc++;
        @(posedge clk);
        #1;
        dividend_valid = 1'b0;
    endtask

    task automatic run_lat(input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
        int  k;
        bit  busy_ok;
        busy_ok = 1'b1;
        issue(a, b);
        k = 0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (quotient_valid) begin
                k = i;
                break;
            end
            if (ready) busy_ok = 1'b0;
        end
        check("latency", 32'(k), 32'(lat));
        check("busy_ready_low", 32'(busy_ok), 32'd1);
        check("ready_at_pulse", 32'(ready), 32'd1);
    endtask

    vec_t tbl[5];
    int   off;
    int   idx;
    int   k;

    initial begin
        tbl[0] = '{a: 4'd13, b: 4'd3, q: 4'd4,  r: 4'd1, z: 1'b0, lat: 5};
        tbl[1] = '{a: 4'd15, b: 4'd1, q: 4'd15, r: 4'd0, z: 1'b0, lat: 5};
        tbl[2] = '{a: 4'd5,  b: 4'd7, q: 4'd0,  r: 4'd5, z: 1'b0, lat: 5};
        tbl[3] = '{a: 4'd9,  b: 4'd0, q: 4'd15, r: 4'd9, z: 1'b1, lat: 1};
        tbl[4] = '{a: 4'd6,  b: 4'd2, q: 4'd3,  r: 4'd0, z: 1'b0, lat: 5};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(quotient_valid), 32'd0);
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_remainder", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(div_by_zero), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Table: values checked by the scoreboard, latency and held outputs here
        for (int i = 0; i < 5; i++) begin
            run_lat(tbl[i].a, tbl[i].b, tbl[i].lat);
            check("tbl_quotient", 32'(quotient), 32'(tbl[i].q));
            check("tbl_remainder", 32'(remainder), 32'(tbl[i].r));
            check("tbl_dbz", 32'(div_by_zero), 32'(tbl[i].z));
        end

        // Request held high during CALC is ignored
        issue(4'd12, 4'd5);
        dividend       = 4'd1;
        divisor        = 4'd1;
        dividend_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        dividend_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("held_req_quotient", 32'(quotient), 32'd2);
        check("held_req_remainder", 32'(remainder), 32'd2);
        check("held_req_outstanding", 32'(sb.size()), 32'd0);

        // Reset mid-CALC abandons the operation
        issue(4'd14, 4'd3);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_valid", 32'(quotient_valid), 32'd0);
        check("midrst_quotient", 32'(quotient), 32'd0);
        check("midrst_remainder", 32'(remainder), 32'd0);
        check("midrst_dbz", 32'(div_by_zero), 32'd0);
        sb.delete();
        n_acc--;
        @(negedge clk);
        rst = 1'b0;
        repeat (8) @(posedge clk);
        run_lat(4'd7, 4'd2, 5);

        // Sweep every operand pair in a scrambled order, back to back
        off = int'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            idx = (i * 37 + off) & 255;
            issue(W'(idx >> 4), W'(idx & 15));
        end

        k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(posedge clk);
            k++;
        end
        repeat (3) @(posedge clk);
        check("drain_outstanding", 32'(sb.size()), 32'd0);
        check("pulse_count", 32'(n_pulse), 32'(n_acc));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
